// File: rtl/demux_gen_buf.sv
// -----------------------------------------------------------------------------
// demux_gen_buf
//
// Valid/ready stream demultiplexer. Each accepted input word is routed to the
// output channel named by in_sel and parked in that channel's one-entry
// register slot until its consumer takes it. Selects that name no existing
// channel are accepted, dropped, and counted in a saturating counter.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    producer has a word
//   in_ready    block accepts this cycle (combinational from out_ready)
//   in_data     word to route
//   in_sel      destination channel index
//   out_valid   bit i: channel i slot holds a word
//   out_ready   bit i: consumer i takes the word
//   out_data    concatenated slots, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   drop_pulse  one-cycle pulse after an out-of-range word was dropped
//   drop_count  saturating count of dropped words
// -----------------------------------------------------------------------------
module demux_gen_buf #(
    parameter int NUM_OUTPUTS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 8,
    localparam int SEL_W      = $clog2(NUM_OUTPUTS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic [SEL_W-1:0]                  in_sel,
    output logic [NUM_OUTPUTS-1:0]            out_valid,
    input  logic [NUM_OUTPUTS-1:0]            out_ready,
    output logic [DATA_WIDTH*NUM_OUTPUTS-1:0] out_data,
    output logic                              drop_pulse,
    output logic [CNT_WIDTH-1:0]              drop_count
);

    logic [NUM_OUTPUTS-1:0]            v_q, v_d;
    logic [DATA_WIDTH*NUM_OUTPUTS-1:0] d_q, d_d;
    logic                              drop_pulse_q, drop_pulse_d;
    logic [CNT_WIDTH-1:0]              drop_count_q, drop_count_d;

    logic sel_hit;
    logic xfer;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + 1'b1;
    endfunction

    // Ready decode: in_ready defaults high so that an in_sel matching no
    // channel (only possible for non power-of-two NUM_OUTPUTS) is always
    // accepted. Matching by equality avoids indexing past the channel range.
    always_comb begin
        in_ready = 1'b1;
        sel_hit  = 1'b0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (in_sel == SEL_W'(i)) begin
                sel_hit  = 1'b1;
                in_ready = ~v_q[i] | out_ready[i];
            end
        end
    end

    assign xfer = in_valid & in_ready;

    // Slot update: a load wins over a same-cycle pop so the slot stays full
    // with the new word; pops on other channels proceed independently.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (xfer && sel_hit && (in_sel == SEL_W'(i))) begin
                v_d[i]                          = 1'b1;
                d_d[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end else if (v_q[i] && out_ready[i]) begin
                v_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        drop_pulse_d = xfer & ~sel_hit;
        drop_count_d = drop_count_q;
        if (drop_pulse_d) begin
            drop_count_d = sat_inc(drop_count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q          <= '0;
            d_q          <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            v_q          <= v_d;
            d_q          <= d_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign out_valid  = v_q;
    assign out_data   = d_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux_gen_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_gen_buf
//
// Directed bench for demux_gen_buf. A 4-channel instance covers streaming,
// back-pressure and channel independence; a 3-channel instance with a 2-bit
// counter covers out-of-range drops and counter saturation. Both share clock
// and reset so a mid-cycle reset can be checked on full slots.
// -----------------------------------------------------------------------------
module tb_demux_gen_buf;

    logic clk;
    logic rst_n;

    // 4-channel instance
    logic        in_valid4;
    logic        in_ready4;
    logic [7:0]  in_data4;
    logic [1:0]  in_sel4;
    logic [3:0]  out_valid4;
    logic [3:0]  out_ready4;
    logic [31:0] out_data4;
    logic        drop_pulse4;
    logic [7:0]  drop_count4;

    // 3-channel instance, 2-bit drop counter
    logic        in_valid3;
    logic        in_ready3;
    logic [7:0]  in_data3;
    logic [1:0]  in_sel3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [23:0] out_data3;
    logic        drop_pulse3;
    logic [1:0]  drop_count3;

    int n_tests = 0;
    int n_fail  = 0;

    demux_gen_buf #(.NUM_OUTPUTS(4), .DATA_WIDTH(8), .CNT_WIDTH(8)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .in_data    (in_data4),
        .in_sel     (in_sel4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .out_data   (out_data4),
        .drop_pulse (drop_pulse4),
        .drop_count (drop_count4)
    );

    demux_gen_buf #(.NUM_OUTPUTS(3), .DATA_WIDTH(8), .CNT_WIDTH(2)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .in_data    (in_data3),
        .in_sel     (in_sel3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready3),
        .out_data   (out_data3),
        .drop_pulse (drop_pulse3),
        .drop_count (drop_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid4  = 1'b0;
        in_data4   = '0;
        in_sel4    = '0;
        out_ready4 = '0;
        in_valid3  = 1'b0;
        in_data3   = '0;
        in_sel3    = '0;
        out_ready3 = '0;

        step();
        chk("rst_valid4", 32'(out_valid4), 32'h0);
        chk("rst_data4",  out_data4,       32'h0);
        chk("rst_cnt4",   32'(drop_count4), 32'h0);
        chk("rst_pulse3", 32'(drop_pulse3), 32'h0);
        rst_n = 1'b1;
        step();

        // Streaming: every consumer ready, one word per cycle round-robin.
        out_ready4 = 4'hF;
        for (int k = 0; k < 8; k++) begin
            in_valid4 = 1'b1;
            in_data4  = 8'hA0 + 8'(k);
            in_sel4   = 2'(k % 4);
            #1;
            chk("stream_rdy", 32'(in_ready4), 32'h1);
            step();
            chk("stream_vld", 32'(out_valid4), 32'(4'b0001 << (k % 4)));
            chk("stream_dat", 32'(out_data4[(k % 4)*8 +: 8]), 32'(8'hA0 + 8'(k)));
        end
        in_valid4 = 1'b0;
        step();
        chk("stream_drain", 32'(out_valid4), 32'h0);

        // Back-pressure on channel 2.
        out_ready4 = 4'b1011;
        in_valid4  = 1'b1;
        in_sel4    = 2'd2;
        in_data4   = 8'h11;
        #1;
        chk("bp_rdy_first", 32'(in_ready4), 32'h1);
        step();
        chk("bp_vld_first", 32'(out_valid4), 32'h4);
        chk("bp_dat_first", 32'(out_data4[23:16]), 32'h11);
        in_data4 = 8'h22;
        #1;
        chk("bp_rdy_stall", 32'(in_ready4), 32'h0);
        step();
        chk("bp_dat_held", 32'(out_data4[23:16]), 32'h11);
        chk("bp_vld_held", 32'(out_valid4), 32'h4);
        out_ready4 = 4'b1111;
        #1;
        chk("bp_rdy_pop", 32'(in_ready4), 32'h1);
        step();
        chk("bp_vld_swap", 32'(out_valid4), 32'h4);
        chk("bp_dat_swap", 32'(out_data4[23:16]), 32'h22);

        // Independence: channel 1 full and stalled, channel 3 still accepts.
        out_ready4 = 4'b0000;
        in_sel4    = 2'd1;
        in_data4   = 8'h44;
        #1;
        chk("ind_rdy_ch1", 32'(in_ready4), 32'h1);
        step();
        chk("ind_vld_ch1", 32'(out_valid4), 32'h6);
        in_data4 = 8'h55;
        #1;
        chk("ind_rdy_ch1_full", 32'(in_ready4), 32'h0);
        in_sel4  = 2'd3;
        in_data4 = 8'h33;
        #1;
        chk("ind_rdy_ch3", 32'(in_ready4), 32'h1);
        step();
        in_valid4 = 1'b0;
        chk("ind_vld_all", 32'(out_valid4), 32'hE);
        chk("ind_dat_ch3", 32'(out_data4[31:24]), 32'h33);
        chk("ind_dat_ch1", 32'(out_data4[15:8]), 32'h44);
        chk("ind_dat_ch2", 32'(out_data4[23:16]), 32'h22);
        chk("ind_cnt4", 32'(drop_count4), 32'h0);

        // Drops on the 3-channel instance.
        out_ready3 = 3'b111;
        in_valid3  = 1'b1;
        in_sel3    = 2'd3;
        in_data3   = 8'h99;
        #1;
        chk("drop_rdy", 32'(in_ready3), 32'h1);
        step();
        in_valid3 = 1'b0;
        chk("drop_pulse_hi", 32'(drop_pulse3), 32'h1);
        chk("drop_cnt1", 32'(drop_count3), 32'h1);
        chk("drop_no_vld", 32'(out_valid3), 32'h0);
        step();
        chk("drop_pulse_lo", 32'(drop_pulse3), 32'h0);
        chk("drop_cnt_hold", 32'(drop_count3), 32'h1);

        // Stalled channel 0 must not block out-of-range selects.
        out_ready3 = 3'b000;
        in_valid3  = 1'b1;
        in_sel3    = 2'd0;
        in_data3   = 8'h66;
        step();
        chk("d3_vld_ch0", 32'(out_valid3), 32'h1);
        chk("d3_dat_ch0", 32'(out_data3[7:0]), 32'h66);
        chk("d3_pulse_load", 32'(drop_pulse3), 32'h0);
        #1;
        chk("d3_rdy_ch0_full", 32'(in_ready3), 32'h0);
        in_sel3 = 2'd3;
        #1;
        chk("d3_rdy_oor", 32'(in_ready3), 32'h1);
        // Four back-to-back drops: total five, counter saturates at 3.
        for (int k = 0; k < 4; k++) begin
            step();
        end
        in_valid3 = 1'b0;
        chk("sat_cnt", 32'(drop_count3), 32'h3);
        chk("sat_pulse", 32'(drop_pulse3), 32'h1);
        chk("sat_ch0_kept", 32'(out_data3[7:0]), 32'h66);
        chk("sat_vld_kept", 32'(out_valid3), 32'h1);
        step();
        chk("sat_pulse_lo", 32'(drop_pulse3), 32'h0);

        // Mid-cycle asynchronous reset with slots full.
        rst_n = 1'b0;
        #1;
        chk("arst_vld4", 32'(out_valid4), 32'h0);
        chk("arst_dat4", out_data4, 32'h0);
        chk("arst_vld3", 32'(out_valid3), 32'h0);
        chk("arst_cnt3", 32'(drop_count3), 32'h0);
        chk("arst_dat3", 32'(out_data3), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_vld4", 32'(out_valid4), 32'h0);
        chk("post_rst_rdy4", 32'(in_ready4), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_gen_buf.md
# demux_gen_buf

Parameterised valid/ready stream demultiplexer: routes each accepted input word to one of NUM_OUTPUTS output channels chosen by a per-word select, through a one-entry register slot per channel. It is the distribution-side counterpart of the concatenated-bus N:1 mux used in the datapath, for example fanning a result bus out to per-unit consumers. Out-of-range selects are accepted, dropped and counted, never written to any channel.

## Interface
- NUM_OUTPUTS, 2: number of output channels; must be >= 2.
- DATA_WIDTH, 32: width of each data word.
- CNT_WIDTH, 8: width of the saturating drop counter.
- SEL_W (localparam) = $clog2(NUM_OUTPUTS).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts this cycle.
- in_data  in  DATA_WIDTH  word to route.
- in_sel  in  SEL_W  destination channel index.
- out_valid  out  NUM_OUTPUTS  bit i: channel i slot holds a word.
- out_ready  in  NUM_OUTPUTS  bit i: consumer i takes the word.
- out_data  out  DATA_WIDTH*NUM_OUTPUTS  concatenated; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- drop_pulse  out  1  registered one-cycle pulse: out-of-range word dropped.
- drop_count  out  CNT_WIDTH  saturating count of dropped words.

## Operation
- Per-channel state: valid bit v[i] and data register d[i]. out_valid[i] = v[i], out_data slice i = d[i].
- in_sel < NUM_OUTPUTS (in range): in_ready = ~v[in_sel] | out_ready[in_sel]. Combinational path out_ready -> in_ready is intentional.
- in_sel >= NUM_OUTPUTS (only possible when NUM_OUTPUTS is not a power of two): in_ready = 1.
- Input transfer occurs when in_valid & in_ready.
- Channel i update each cycle, with load_i = in-range transfer with in_sel == i and pop_i = v[i] & out_ready[i]:
  - load_i: d[i] <= in_data, v[i] <= 1, whether or not pop_i is also true (same-cycle pop and load keeps the slot full with the new word).
  - pop_i only: v[i] <= 0; d[i] holds its value.
  - Neither: hold.
- Channels are independent. Pops on any set of channels occur in the same cycle as a load to any one channel.
- Out-of-range transfer: no channel changes. drop_pulse <= 1 next cycle. drop_count increments and saturates at 2^CNT_WIDTH-1.
- drop_pulse is 0 in every cycle not following an out-of-range transfer.
- in_ready is a function only of current state, in_sel and out_ready. It does not depend on in_valid.
- X on in_sel or in_data while in_valid = 0 must not corrupt state.

## Timing
- Reset (rst_n low, asynchronous assert): v = 0 for all channels, d = 0 for all channels, drop_pulse = 0, drop_count = 0. Hence out_valid = 0 and out_data = 0.
- Reset deassertion takes effect at the first rising edge with rst_n high. Reset mid-stream discards all held words without an output handshake.
- Latency: a word accepted at edge N is visible on out_valid/out_data of its channel after edge N, and consumable in cycle N+1.
- Throughput: one word per cycle into a channel whose consumer holds out_ready high. One word per cycle overall.
- A full channel with out_ready low back-pressures only words selecting that channel. in_ready stays high for other channels and for out-of-range selects.
- drop_pulse and drop_count update one cycle after the dropping transfer.

## Test plan
- Reset: drive rst_n = 0 mid-cycle with channels full -> out_valid = 0, out_data = 0, drop_count = 0 immediately, without waiting for clk.
- Streaming: NUM_OUTPUTS = 4, all out_ready = 1, send 0xA0..0xA7 with in_sel = 0,1,2,3,0,1,2,3 -> each word appears on its channel exactly one cycle after acceptance; in_ready is 1 throughout.
- Back-pressure: out_ready[2] = 0, send 0x11 then 0x22 to channel 2 -> 0x11 held; in_ready = 0 for the second word; then out_ready[2] = 1 -> 0x11 popped and 0x22 loaded in the same cycle; v[2] stays 1 with d[2] = 0x22.
- Independence: channel 1 full and stalled, send 0x33 to channel 3 -> accepted; channel 1 is unchanged.
- Drop: NUM_OUTPUTS = 3, in_sel = 3 with in_valid = 1 -> in_ready = 1; no out_valid change; drop_pulse high one cycle; drop_count = 1. With CNT_WIDTH = 2, after 5 drops drop_count = 3.
- Random: constrained-random in_sel/out_ready over 10k cycles with scoreboard per channel -> words are neither lost nor duplicated and arrive in order; dropped words equal drop_count below saturation.
